axis_tx_hssi_sf_fifo: RTL and testbench

//  Store-and-forward buffer directly upstream of the HSSI TX AXIS pipeline stage.

---
 rtl/ofs_fim_eth_if_pkg.sv | 21 ++
 rtl/axis_tx_sf_ram.sv | 22 ++
 rtl/axis_tx_hssi_sf_fifo.sv | 122 ++++++++++++
 tb/tb_axis_tx_hssi_sf_fifo.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/ofs_fim_eth_if_pkg.sv
// Shared HSSI TX AXIS definitions: default beat layout and store-and-forward buffer constants.
package ofs_fim_eth_if_pkg;

  localparam int ETH_TDATA_W = 512;
  localparam int ETH_TUSER_W = 10;
  localparam int SF_DEPTH    = 512;
  localparam int SF_CNT_W    = 16;

  typedef struct packed {
    logic [ETH_TDATA_W-1:0]   tdata;
    logic [ETH_TDATA_W/8-1:0] tkeep;
    logic                     tlast;
    logic [ETH_TUSER_W-1:0]   tuser;
  } axis_tx_beat_t;

  // One extra pointer bit distinguishes full from empty.
  function automatic int sf_ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/axis_tx_sf_ram.sv
// Simple dual-port beat RAM; the read port is registered and holds while re is low.
module axis_tx_sf_ram #(
  parameter int DEPTH = 512,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/axis_tx_hssi_sf_fifo.sv
// Store-and-forward TX buffer; oversize packets fall back to cut-through.
// Optional AXIS_TX_SF_DROP_ERR_EN discards packets whose tlast carries tuser[0].
import ofs_fim_eth_if_pkg::*;

module axis_tx_hssi_sf_fifo #(
  parameter int TDATA_WIDTH = ETH_TDATA_W,
  parameter int TUSER_WIDTH = ETH_TUSER_W,
  parameter int DEPTH       = SF_DEPTH,
  parameter int CNT_WIDTH   = SF_CNT_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_tvalid,
  output logic                     s_tready,
  input  logic [TDATA_WIDTH-1:0]   s_tdata,
  input  logic [TDATA_WIDTH/8-1:0] s_tkeep,
  input  logic                     s_tlast,
  input  logic [TUSER_WIDTH-1:0]   s_tuser,
  output logic                     m_tvalid,
  input  logic                     m_tready,
  output logic [TDATA_WIDTH-1:0]   m_tdata,
  output logic [TDATA_WIDTH/8-1:0] m_tkeep,
  output logic                     m_tlast,
  output logic [TUSER_WIDTH-1:0]   m_tuser,
  output logic [CNT_WIDTH-1:0]     pkt_cnt,
  output logic [CNT_WIDTH-1:0]     drop_cnt,
  output logic                     cut_thru
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = sf_ptr_w(DEPTH);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic [TDATA_WIDTH-1:0]   tdata;
    logic [TDATA_WIDTH/8-1:0] tkeep;
    logic                     tlast;
    logic [TUSER_WIDTH-1:0]   tuser;
  } beat_t;

  logic [PW-1:0] wr_ptr, cm_ptr, rd_ptr, rd_lim;
  logic          rdy_q, full, wr_en, rd_en, m_take, commit, drop, ct_done, ct_open;
  logic          cnt_inc, cnt_dec;
  beat_t         wr_beat, rd_beat;

  assign full     = (wr_ptr ^ rd_ptr) == PW'(DEPTH);
  assign s_tready = rdy_q && !full;
  assign wr_en    = s_tvalid && s_tready;
  // ct_open: the oversize packet's tlast has not been stored yet.
  assign ct_open  = cut_thru && !ct_done;

`ifdef AXIS_TX_SF_DROP_ERR_EN
  assign drop = wr_en && s_tlast && s_tuser[0] && !ct_open;
`else
  assign drop = 1'b0;
`endif

  assign commit  = wr_en && s_tlast && !drop;
  assign rd_lim  = ct_open ? wr_ptr : cm_ptr;
  assign m_take  = m_tvalid && m_tready;
  assign rd_en   = (rd_ptr != rd_lim) && (!m_tvalid || m_tready);
  assign cnt_inc = commit && (pkt_cnt != CNT_MAX);
  assign cnt_dec = m_take && m_tlast && (pkt_cnt != '0);

  assign wr_beat = '{tdata: s_tdata, tkeep: s_tkeep, tlast: s_tlast, tuser: s_tuser};
  assign m_tdata = rd_beat.tdata;
  assign m_tkeep = rd_beat.tkeep;
  assign m_tlast = rd_beat.tlast;
  assign m_tuser = rd_beat.tuser;

  axis_tx_sf_ram #(.DEPTH(DEPTH), .W($bits(beat_t))) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (wr_beat),
    .re    (rd_en),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rd_beat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_q    <= 1'b0;
      wr_ptr   <= '0;
      cm_ptr   <= '0;
      rd_ptr   <= '0;
      m_tvalid <= 1'b0;
      pkt_cnt  <= '0;
      cut_thru <= 1'b0;
      ct_done  <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      if (drop)       wr_ptr <= cm_ptr;
      else if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (commit) cm_ptr <= wr_ptr + PW'(1);
      if (rd_en) rd_ptr <= rd_ptr + PW'(1);
      // Output register is show-ahead: it refills in the cycle it is emptied.
      if (rd_en)       m_tvalid <= 1'b1;
      else if (m_take) m_tvalid <= 1'b0;
      if (cnt_inc && !cnt_dec)      pkt_cnt <= pkt_cnt + CNT_WIDTH'(1);
      else if (cnt_dec && !cnt_inc) pkt_cnt <= pkt_cnt - CNT_WIDTH'(1);
      // A full buffer with nothing committed can only hold one oversize packet.
      if (commit && ct_open) ct_done <= 1'b1;
      if (cut_thru && m_take && m_tlast) begin
        cut_thru <= 1'b0;
        ct_done  <= 1'b0;
      end else if (full && pkt_cnt == '0 && !cut_thru) begin
        cut_thru <= 1'b1;
      end
    end
  end

`ifdef AXIS_TX_SF_DROP_ERR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          drop_cnt <= '0;
    else if (drop && drop_cnt != CNT_MAX) drop_cnt <= drop_cnt + CNT_WIDTH'(1);
  end
`else
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_axis_tx_hssi_sf_fifo.sv
// Directed bench for axis_tx_hssi_sf_fifo (small DEPTH so oversize packets are cheap).
module tb_axis_tx_hssi_sf_fifo;

  localparam int DW = 32;
  localparam int UW = 4;
  localparam int DEPTH = 8;
  localparam int CW = 8;

  logic          clk, rst;
  logic          s_tvalid, s_tready, s_tlast;
  logic [DW-1:0] s_tdata;
  logic [DW/8-1:0] s_tkeep;
  logic [UW-1:0] s_tuser;
  logic          m_tvalid, m_tready, m_tlast;
  logic [DW-1:0] m_tdata;
  logic [DW/8-1:0] m_tkeep;
  logic [UW-1:0] m_tuser;
  logic [CW-1:0] pkt_cnt, drop_cnt;
  logic          cut_thru;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] rx_data [$];
  logic          rx_last [$];
  int            rx_cyc  [$];
  int            cyc = 0;
  int            ct_cycles = 0;

  axis_tx_hssi_sf_fifo #(.TDATA_WIDTH(DW), .TUSER_WIDTH(UW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tkeep(s_tkeep),
    .s_tlast(s_tlast), .s_tuser(s_tuser),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tkeep(m_tkeep),
    .m_tlast(m_tlast), .m_tuser(m_tuser),
    .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt), .cut_thru(cut_thru)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Beat monitor on the falling edge; inputs only change 1 unit after the rising edge.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (cut_thru) ct_cycles <= ct_cycles + 1;
    if (!rst && m_tvalid && m_tready) begin
      rx_data.push_back(m_tdata);
      rx_last.push_back(m_tlast);
      rx_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic l, input logic [UW-1:0] u);
    int n;
    n = 0;
    s_tvalid = 1'b1; s_tdata = d; s_tlast = l; s_tuser = u; s_tkeep = '1;
    while (!s_tready && n < 200) begin tick(); n++; end
    check("send_rdy", s_tready, 1'b1);
    tick();
    s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = '0;
  endtask

  task automatic wait_beats(input int target);
    int n;
    n = 0;
    while (rx_data.size() < target && n < 300) begin tick(); n++; end
    check("rx_count", rx_data.size(), target);
  endtask

  int base;

  initial begin
    rst = 1'b1; s_tvalid = 1'b0; s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0;
    s_tuser = '0; m_tready = 1'b0;
    ticks(2);
    check("rst_s_tready", s_tready, 1'b0);
    check("rst_m_tvalid", m_tvalid, 1'b0);
    check("rst_pkt_cnt", pkt_cnt, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    check("rst_cut_thru", cut_thru, 1'b0);
    rst = 1'b0;
    #1;
    check("rel_s_tready_low", s_tready, 1'b0);
    tick();
    check("rel_s_tready_high", s_tready, 1'b1);

    // 1: single beat, two-cycle latency to m_tvalid
    m_tready = 1'b1;
    send_beat(32'h11, 1'b1, '0);
    check("t1_lat_n1", m_tvalid, 1'b0);
    check("t1_pkt_cnt1", pkt_cnt, 1);
    tick();
    check("t1_lat_n2", m_tvalid, 1'b1);
    check("t1_data", m_tdata, 32'h11);
    check("t1_last", m_tlast, 1'b1);
    check("t1_keep", m_tkeep, 4'hF);
    tick();
    check("t1_drained", m_tvalid, 1'b0);
    check("t1_pkt_cnt0", pkt_cnt, 0);

    // 2: gapped input, gapless output
    base = rx_data.size();
    for (int i = 0; i < 4; i++) begin
      send_beat(32'h20 + i, i == 3, '0);
      ticks(2);
    end
    wait_beats(base + 4);
    for (int i = 0; i < 4; i++) begin
      check("t2_data", rx_data[base+i], 32'h20 + i);
      check("t2_last", rx_last[base+i], i == 3);
      check("t2_no_bubble", rx_cyc[base+i] - rx_cyc[base], i);
    end

    // 3: three packets held back, then released in order
    m_tready = 1'b0;
    base = rx_data.size();
    send_beat(32'h30, 1'b1, '0);
    send_beat(32'h31, 1'b0, '0);
    send_beat(32'h32, 1'b1, '0);
    send_beat(32'h33, 1'b0, '0);
    send_beat(32'h34, 1'b0, '0);
    send_beat(32'h35, 1'b1, '0);
    ticks(2);
    check("t3_pkt_cnt3", pkt_cnt, 3);
    check("t3_head_valid", m_tvalid, 1'b1);
    check("t3_head_data", m_tdata, 32'h30);
    ticks(3);
    check("t3_stall_stable", m_tdata, 32'h30);
    m_tready = 1'b1;
    wait_beats(base + 6);
    for (int i = 0; i < 6; i++) begin
      check("t3_data", rx_data[base+i], 32'h30 + i);
      check("t3_last", rx_last[base+i], (i == 0) || (i == 2) || (i == 5));
    end
    tick();
    check("t3_pkt_cnt0", pkt_cnt, 0);

    // 4: oversize packet forces cut-through
    base = rx_data.size();
    check("t4_ct_idle", ct_cycles, 0);
    for (int i = 0; i < DEPTH + 4; i++) send_beat(32'h40 + i, i == DEPTH + 3, '0);
    wait_beats(base + DEPTH + 4);
    for (int i = 0; i < DEPTH + 4; i++)
      check("t4_data", rx_data[base+i], 32'h40 + i);
    check("t4_last", rx_last[base+DEPTH+3], 1'b1);
    check("t4_ct_seen", ct_cycles > 0, 1'b1);
    ticks(2);
    check("t4_ct_clear", cut_thru, 1'b0);
    check("t4_pkt_cnt0", pkt_cnt, 0);

    // 5: errored packet
    base = rx_data.size();
    send_beat(32'h50, 1'b0, '0);
    send_beat(32'h51, 1'b1, 4'h1);
    ticks(6);
`ifdef AXIS_TX_SF_DROP_ERR_EN
    check("t5_no_output", rx_data.size(), base);
    check("t5_drop_cnt", drop_cnt, 1);
    check("t5_pkt_cnt", pkt_cnt, 0);
    send_beat(32'h52, 1'b1, '0);
    wait_beats(base + 1);
    check("t5_next_data", rx_data[base], 32'h52);
`else
    check("t5_fwd_count", rx_data.size(), base + 2);
    check("t5_fwd_data", rx_data[base+1], 32'h51);
    check("t5_drop_cnt0", drop_cnt, 0);
`endif

    // 6: reset mid-packet, then mid-drain
    send_beat(32'h60, 1'b0, '0);
    send_beat(32'h61, 1'b0, '0);
    rst = 1'b1;
    #1;
    check("t6a_s_tready", s_tready, 1'b0);
    check("t6a_pkt_cnt", pkt_cnt, 0);
    tick();
    rst = 1'b0;
    tick();
    m_tready = 1'b0;
    send_beat(32'h62, 1'b0, '0);
    send_beat(32'h63, 1'b1, '0);
    ticks(2);
    check("t6b_pre_valid", m_tvalid, 1'b1);
    check("t6b_pre_cnt", pkt_cnt, 1);
    rst = 1'b1;
    #1;
    check("t6b_m_tvalid", m_tvalid, 1'b0);
    check("t6b_pkt_cnt", pkt_cnt, 0);
    check("t6b_drop_cnt", drop_cnt, 0);
    check("t6b_cut_thru", cut_thru, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    m_tready = 1'b1;
    base = rx_data.size();
    send_beat(32'h70, 1'b0, '0);
    send_beat(32'h71, 1'b1, '0);
    wait_beats(base + 2);
    ticks(4);
    check("t6_only_new", rx_data.size(), base + 2);
    check("t6_data0", rx_data[base], 32'h70);
    check("t6_data1", rx_data[base+1], 32'h71);
    check("t6_last", rx_last[base+1], 1'b1);
    check("t6_pkt_cnt0", pkt_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
